// File: rtl/pipe_scheduler_if.sv
// Handshake bundle between the frame/game-state source and the pipe scheduler.
`timescale 1ns/1ps
interface pipe_scheduler_if;
  logic               frame_tick;
  logic [1:0]         game_status;
  logic signed [10:0] oxbuf;
  logic [10:0]        oybuf;
  logic               pipe_refresh;

  modport master (
    output frame_tick, game_status,
    input  oxbuf, oybuf, pipe_refresh
  );

  modport slave (
    input  frame_tick, game_status,
    output oxbuf, oybuf, pipe_refresh
  );
endinterface

// File: rtl/pipe_scheduler.sv
// Pipe obstacle scheduler: scrolls the pipe left once per movement step while playing and
// respawns it at the right edge with an LFSR-derived gap height.
`timescale 1ns/1ps
module pipe_scheduler #(
  parameter int         SCREEN_W        = 640,
  parameter int         PIPE_W          = 64,
  parameter int         STEP            = 2,
  parameter int         FRAMES_PER_STEP = 1,
  parameter int         Y_INIT          = 200,
  parameter int         Y_MIN           = 80,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input logic             clock,
  input logic             reset,
  pipe_scheduler_if.slave bus
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic signed [10:0] X_SPAWN = 11'(SCREEN_W);
  localparam logic signed [10:0] X_LIMIT = 11'(-PIPE_W);
  localparam logic signed [10:0] X_STEP  = 11'(STEP);
  localparam logic [10:0]        Y_RESET = 11'(Y_INIT);
  localparam logic [10:0]        Y_BASE  = 11'(Y_MIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t             r_state;
  logic signed [10:0] r_oxbuf;
  logic [10:0]        r_oybuf;
  logic               r_refresh;
  logic [CNT_W-1:0]   r_frameCnt;
  logic [7:0]         r_lfsr;

  state_t             w_nextState;
  logic signed [10:0] w_nextX;
  logic               w_respawn;
  logic               w_stepDue;
  logic [7:0]         w_lfsrNext;
  logic [10:0]        w_respawnY;

  assign bus.oxbuf        = r_oxbuf;
  assign bus.oybuf        = r_oybuf;
  assign bus.pipe_refresh = r_refresh;

  // The status seen on an edge decides that edge's behaviour, so decode it combinationally.
  always_comb begin
    w_nextState = IDLE;
    case (bus.game_status)
      2'd2:    w_nextState = RUN;
      2'd3:    w_nextState = FREEZE;
      default: w_nextState = IDLE;
    endcase
    w_stepDue  = (r_frameCnt == CNT_MAX);
    w_nextX    = r_oxbuf - X_STEP;
    w_respawn  = (w_nextX <= X_LIMIT);
    w_lfsrNext = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    w_respawnY = Y_BASE + {3'b000, r_lfsr};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_oxbuf    <= X_SPAWN;
      r_oybuf    <= Y_RESET;
      r_refresh  <= 1'b0;
      r_frameCnt <= '0;
      r_lfsr     <= LFSR_SEED;
    end else begin
      r_state   <= w_nextState;
      r_refresh <= 1'b0;
      if (bus.frame_tick) begin
        r_lfsr <= w_lfsrNext;
      end
      case (w_nextState)
        IDLE: begin
          // Positions are constant while idle; only reload them when leaving another state.
          if (r_state != IDLE) begin
            r_oxbuf    <= X_SPAWN;
            r_oybuf    <= Y_RESET;
            r_frameCnt <= '0;
          end
        end
        RUN: begin
          if (bus.frame_tick) begin
            if (w_stepDue) begin
              r_frameCnt <= '0;
              if (w_respawn) begin
                r_oxbuf   <= X_SPAWN;
                r_oybuf   <= w_respawnY;
                r_refresh <= 1'b1;
              end else begin
                r_oxbuf <= w_nextX;
              end
            end else begin
              r_frameCnt <= r_frameCnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: default instance plus a FRAMES_PER_STEP=3 instance
// sharing the same stimulus, with a local LFSR model for respawn gap heights.
`timescale 1ns/1ps
module tb_pipe_scheduler;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] status = 2'd0;

  int assertCount = 0;
  int failCount = 0;
  int refreshSeen = 0;
  int refreshBase = 0;
  int yRespawn = 0;
  logic [7:0] lfsrModel = 8'hA5;
  logic [7:0] lfsrBefore = 8'hA5;

  pipe_scheduler_if busA ();
  pipe_scheduler_if busB ();

  assign busA.frame_tick  = tick;
  assign busA.game_status = status;
  assign busB.frame_tick  = tick;
  assign busB.game_status = status;

  pipe_scheduler dutA (
    .clock(clock),
    .reset(reset),
    .bus  (busA.slave)
  );

  pipe_scheduler #(.FRAMES_PER_STEP(3)) dutB (
    .clock(clock),
    .reset(reset),
    .bus  (busB.slave)
  );

  always #5 clock = ~clock;

  // Counts refresh pulses seen on the default instance, sampled away from the active edge.
  always @(negedge clock) begin
    if (busA.pipe_refresh) refreshSeen++;
  end

  function automatic logic [7:0] lfsrStep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Sends n frame ticks two cycles apart; status is applied on the same cycle as each tick.
  task automatic applyStimulus(input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      status     = st;
      tick       = 1'b1;
      lfsrBefore = lfsrModel;
      lfsrModel  = lfsrStep(lfsrModel);
      @(negedge clock);
      tick = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    checkOutput("resetX", busA.oxbuf, 640);
    checkOutput("resetY", busA.oybuf, 200);
    checkOutput("resetRefresh", busA.pipe_refresh, 0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idleX", busA.oxbuf, 640);

    // Five ticks at default rate, then two more to exercise the divided instance.
    applyStimulus(5, 2'd2);
    @(negedge clock);
    checkOutput("run5X", busA.oxbuf, 630);
    checkOutput("run5Y", busA.oybuf, 200);
    checkOutput("run5Pulses", refreshSeen, 0);
    applyStimulus(2, 2'd2);
    checkOutput("run7X", busA.oxbuf, 626);
    checkOutput("div3X", busB.oxbuf, 636);

    // Reset asserted mid-cycle while running takes effect without a clock edge.
    applyStimulus(263, 2'd2);
    checkOutput("midRunX", busA.oxbuf, 100);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncResetX", busA.oxbuf, 640);
    checkOutput("asyncResetRefresh", busA.pipe_refresh, 0);
    @(negedge clock);
    reset = 1'b0;
    lfsrModel = 8'hA5;
    checkOutput("afterResetX", busA.oxbuf, 640);
    checkOutput("afterResetY", busA.oybuf, 200);
    refreshBase = refreshSeen;

    // Full traversal to the respawn boundary; gap Y comes from the reseeded LFSR.
    applyStimulus(351, 2'd2);
    checkOutput("tick351X", busA.oxbuf, -62);
    checkOutput("preRespawnPulses", refreshSeen - refreshBase, 0);
    applyStimulus(1, 2'd2);
    yRespawn = 80 + int'(lfsrBefore);
    checkOutput("respawnX", busA.oxbuf, 640);
    checkOutput("respawnY", busA.oybuf, yRespawn);
    checkOutput("refreshHigh", busA.pipe_refresh, 1);
    @(negedge clock);
    checkOutput("refreshLow", busA.pipe_refresh, 0);
    checkOutput("respawnPulses", refreshSeen - refreshBase, 1);

    // Freeze holds position and gap, then resumes from the held X.
    applyStimulus(10, 2'd2);
    checkOutput("preFreezeX", busA.oxbuf, 620);
    applyStimulus(10, 2'd3);
    checkOutput("frozenX", busA.oxbuf, 620);
    checkOutput("frozenY", busA.oybuf, yRespawn);
    applyStimulus(1, 2'd2);
    checkOutput("resumeX", busA.oxbuf, 618);

    // A tick landing with status 0 at the boundary must not respawn or pulse.
    refreshBase = refreshSeen;
    applyStimulus(340, 2'd2);
    checkOutput("boundaryX", busA.oxbuf, -62);
    applyStimulus(1, 2'd0);
    checkOutput("idleTickX", busA.oxbuf, 640);
    checkOutput("idleTickY", busA.oybuf, 200);
    @(negedge clock);
    checkOutput("idleTickPulses", refreshSeen - refreshBase, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
